// File: rtl/mem_stage_lsu_if.sv
// Memory-stage LSU signal bundle: M-stage access inputs, data-bus handshake and load writeback.
// "master" is the LSU side; "slave" is the pipeline/bus environment side.
interface mem_stage_lsu_if #(
  parameter int XLEN = 2
);
  localparam int W  = 1 << (XLEN + 4);
  localparam int NB = W / 8;

  logic          i_flush;
  logic [W-1:0]  i_alu_out_m;
  logic [W-1:0]  i_haz_b_m;
  logic          i_mem_write_m;
  logic [1:0]    i_result_src_m;
  logic [2:0]    i_f3_m;
  logic          o_stall_m;
  logic          o_dbus_req;
  logic          o_dbus_we;
  logic [W-1:0]  o_dbus_addr;
  logic [W-1:0]  o_dbus_wdata;
  logic [NB-1:0] o_dbus_be;
  logic          i_dbus_gnt;
  logic          i_dbus_rvalid;
  logic [W-1:0]  i_dbus_rdata;
  logic          i_dbus_err;
  logic [W-1:0]  o_load_data_m;
  logic          o_load_valid_m;
  logic [3:0]    o_exception_code_m;

  modport master (
    input  i_flush, i_alu_out_m, i_haz_b_m, i_mem_write_m, i_result_src_m, i_f3_m,
    input  i_dbus_gnt, i_dbus_rvalid, i_dbus_rdata, i_dbus_err,
    output o_stall_m, o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_be,
    output o_load_data_m, o_load_valid_m, o_exception_code_m
  );

  modport slave (
    output i_flush, i_alu_out_m, i_haz_b_m, i_mem_write_m, i_result_src_m, i_f3_m,
    output i_dbus_gnt, i_dbus_rvalid, i_dbus_rdata, i_dbus_err,
    input  o_stall_m, o_dbus_req, o_dbus_we, o_dbus_addr, o_dbus_wdata, o_dbus_be,
    input  o_load_data_m, o_load_valid_m, o_exception_code_m
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: runs one data-bus access per M-stage load/store,
// stalls the pipeline while it is outstanding, aligns/extends load data and reports exceptions.
module mem_stage_lsu #(
  parameter int XLEN = 2
) (
  input logic            i_clk,
  input logic            i_rst,
  mem_stage_lsu_if.master bus
);
  localparam int W    = 1 << (XLEN + 4);
  localparam int NB   = W / 8;
  localparam int OFFW = XLEN + 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t          state;
  logic            req;
  logic            we;
  logic [W-1:0]    addr;
  logic [W-1:0]    wdata;
  logic [NB-1:0]   be;
  logic [OFFW-1:0] off_reg;
  logic [2:0]      f3_reg;
  logic            store_reg;
  logic            killed;
  logic            load_valid;
  logic [W-1:0]    load_data;
  logic [3:0]      fault_code;

  logic            is_store;
  logic            is_load;
  logic            access;
  logic            misaligned;
  logic            start;
  logic [2:0]      align_mask;
  logic [3:0]      size_bytes;
  logic [OFFW-1:0] offset;
  logic [NB-1:0]   size_mask;
  logic [NB-1:0]   be_next;
  logic [W-1:0]    wdata_next;
  logic [3:0]      size_reg;
  logic [7:0]      size_bits;
  logic [W-1:0]    shifted;
  logic [W-1:0]    extended;
  logic            sign_bit;
  logic [3:0]      exc_code;

  // Store wins when both store and load are flagged.
  assign is_store   = bus.i_mem_write_m;
  assign is_load    = ~bus.i_mem_write_m & (bus.i_result_src_m == 2'b01);
  assign access     = is_store | is_load;
  assign size_bytes = 4'd1 << bus.i_f3_m[1:0];
  assign offset     = bus.i_alu_out_m[OFFW-1:0];

  always_comb begin
    align_mask = 3'b111;
    case (bus.i_f3_m[1:0])
      2'b00:   align_mask = 3'b000;
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  // A doubleword on a 32-bit bus cannot be performed, so it is reported as misaligned.
  assign misaligned = ((XLEN == 1) && (bus.i_f3_m[1:0] == 2'b11)) ||
                      ((bus.i_alu_out_m[2:0] & align_mask) != 3'b000);
  assign start      = (state == IDLE) & access & ~misaligned & ~bus.i_flush;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_size_mask
      assign size_mask[gi] = (4'(gi) < size_bytes);
    end
  endgenerate

  assign be_next    = size_mask << offset;
  assign wdata_next = bus.i_haz_b_m << {offset, 3'b000};

  // Load alignment: move the addressed lane down to bit 0, then extend past the access size.
  assign size_reg  = 4'd1 << f3_reg[1:0];
  assign size_bits = {1'b0, size_reg, 3'b000};
  assign shifted   = bus.i_dbus_rdata >> {off_reg, 3'b000};

  always_comb begin
    sign_bit = 1'b0;
    case (f3_reg[1:0])
      2'b00:   sign_bit = shifted[7];
      2'b01:   sign_bit = shifted[15];
      2'b10:   sign_bit = shifted[31];
      default: sign_bit = shifted[W-1];
    endcase
    sign_bit = sign_bit & ~f3_reg[2];
  end

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_extend
      assign extended[gi] = (8'(gi) < size_bits) ? shifted[gi] : sign_bit;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      req        <= 1'b0;
      we         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      be         <= '0;
      off_reg    <= '0;
      f3_reg     <= '0;
      store_reg  <= 1'b0;
      killed     <= 1'b0;
      load_valid <= 1'b0;
      load_data  <= '0;
      fault_code <= 4'hF;
    end else begin
      load_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= REQ;
            req       <= 1'b1;
            we        <= is_store;
            addr      <= {bus.i_alu_out_m[W-1:OFFW], {OFFW{1'b0}}};
            wdata     <= wdata_next;
            be        <= be_next;
            off_reg   <= offset;
            f3_reg    <= bus.i_f3_m;
            store_reg <= is_store;
            killed    <= 1'b0;
          end
        end
        REQ: begin
          if (bus.i_dbus_gnt) begin
            // Once granted the bus owes a response, so a flush only marks the access dead.
            state  <= RESP;
            req    <= 1'b0;
            be     <= '0;
            killed <= bus.i_flush;
          end else if (bus.i_flush) begin
            state <= IDLE;
            req   <= 1'b0;
            be    <= '0;
          end
        end
        RESP: begin
          if (bus.i_flush) begin
            killed <= 1'b1;
          end
          if (bus.i_dbus_rvalid) begin
            state      <= DONE;
            fault_code <= 4'hF;
            if (!(killed || bus.i_flush)) begin
              if (bus.i_dbus_err) begin
                fault_code <= store_reg ? 4'd7 : 4'd5;
              end else if (!store_reg) begin
                load_data  <= extended;
                load_valid <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          fault_code <= 4'hF;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    exc_code = 4'hF;
    if (state == DONE) begin
      exc_code = fault_code;
    end else if ((state == IDLE) && access && misaligned && !i_rst) begin
      exc_code = is_store ? 4'd6 : 4'd4;
    end
  end

  assign bus.o_stall_m          = start | (state == REQ) | (state == RESP);
  assign bus.o_dbus_req         = req;
  assign bus.o_dbus_we          = we;
  assign bus.o_dbus_addr        = addr;
  assign bus.o_dbus_wdata       = wdata;
  assign bus.o_dbus_be          = be;
  assign bus.o_load_data_m      = load_data;
  assign bus.o_load_valid_m     = load_valid;
  assign bus.o_exception_code_m = exc_code;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (64-bit bus): each access is driven through the
// request/grant/response handshake and its observed behaviour checked against hand-computed values.
module tb_mem_stage_lsu;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  mem_stage_lsu_if #(.XLEN(2)) bus ();

  mem_stage_lsu #(.XLEN(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Per-access observations, filled by run_access.
  int          r_stall;
  int          r_req;
  bit          r_stable;
  bit          r_done;
  logic [63:0] r_addr;
  logic [7:0]  r_be;
  logic [63:0] r_wdata;
  logic        r_we;
  logic        r_valid;
  logic [63:0] r_data;
  logic [3:0]  r_code;
  logic        r_req_end;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // gnt_cycle: grant on this req cycle; resp_delay: RESP cycle carrying rvalid;
  // flush_req: flush on this req cycle (0 = never); flush_resp: flush in first RESP cycle.
  task automatic run_access(input logic [63:0] addr, input logic [63:0] hazb,
                            input bit write, input bit load, input logic [2:0] f3,
                            input int gnt_cycle, input int resp_delay,
                            input logic [63:0] rdata, input bit err,
                            input int flush_req, input bit flush_resp);
    bit granted;
    int resp_cnt;
    @(posedge clk); #1;
    bus.i_alu_out_m    = addr;
    bus.i_haz_b_m      = hazb;
    bus.i_mem_write_m  = write;
    bus.i_result_src_m = load ? 2'b01 : 2'b00;
    bus.i_f3_m         = f3;
    r_stall = 0; r_req = 0; r_stable = 1'b1; r_done = 1'b0;
    granted = 1'b0; resp_cnt = 0;
    for (int cyc = 0; cyc < 60 && !r_done; cyc++) begin
      #1;
      if (!bus.o_stall_m) begin
        r_valid   = bus.o_load_valid_m;
        r_data    = bus.o_load_data_m;
        r_code    = bus.o_exception_code_m;
        r_req_end = bus.o_dbus_req;
        r_done    = 1'b1;
      end else begin
        r_stall++;
        if (bus.o_dbus_req) begin
          r_req++;
          if (r_req == 1) begin
            r_addr = bus.o_dbus_addr; r_be = bus.o_dbus_be;
            r_wdata = bus.o_dbus_wdata; r_we = bus.o_dbus_we;
          end else if (r_addr !== bus.o_dbus_addr || r_be !== bus.o_dbus_be ||
                       r_wdata !== bus.o_dbus_wdata || r_we !== bus.o_dbus_we) begin
            r_stable = 1'b0;
          end
          if (flush_req != 0 && r_req == flush_req) begin
            bus.i_flush = 1'b1;
            bus.i_mem_write_m = 1'b0; bus.i_result_src_m = 2'b00;
          end else if (r_req == gnt_cycle) begin
            bus.i_dbus_gnt = 1'b1;
            granted = 1'b1;
          end
        end else if (granted) begin
          resp_cnt++;
          if (flush_resp && resp_cnt == 1) begin
            bus.i_flush = 1'b1;
            bus.i_mem_write_m = 1'b0; bus.i_result_src_m = 2'b00;
          end
          if (resp_cnt == resp_delay) begin
            bus.i_dbus_rvalid = 1'b1;
            bus.i_dbus_rdata  = rdata;
            bus.i_dbus_err    = err;
          end
        end
        @(posedge clk); #1;
        bus.i_dbus_gnt = 1'b0; bus.i_dbus_rvalid = 1'b0;
        bus.i_dbus_err = 1'b0; bus.i_flush = 1'b0;
      end
    end
    bus.i_mem_write_m = 1'b0; bus.i_result_src_m = 2'b00;
    check("done_reached", r_done, 1'b1);
    $display("txn addr=0x%0h we=%0d f3=%0d stall=%0d req=%0d be=0x%0h wdata=0x%0h valid=%0d data=0x%0h code=%0d",
             addr, write, f3, r_stall, r_req, r_be, r_wdata, r_valid, r_data, r_code);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1;
    bus.i_flush = 1'b0; bus.i_alu_out_m = '0; bus.i_haz_b_m = '0;
    bus.i_mem_write_m = 1'b0; bus.i_result_src_m = 2'b00; bus.i_f3_m = 3'b000;
    bus.i_dbus_gnt = 1'b0; bus.i_dbus_rvalid = 1'b0; bus.i_dbus_rdata = '0; bus.i_dbus_err = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req",   bus.o_dbus_req, 1'b0);
    check("rst_be",    bus.o_dbus_be, 8'h00);
    check("rst_stall", bus.o_stall_m, 1'b0);
    check("rst_valid", bus.o_load_valid_m, 1'b0);
    check("rst_data",  bus.o_load_data_m, 64'h0);
    check("rst_code",  bus.o_exception_code_m, 4'hF);
    @(posedge clk); #1; rst = 1'b0;

    // LD, same-cycle grant, next-cycle response.
    run_access(64'h1000, 64'h0, 0, 1, 3'b011, 1, 1, 64'h1122334455667788, 0, 0, 0);
    check("ld_stall", r_stall, 3);
    check("ld_req",   r_req, 1);
    check("ld_addr",  r_addr, 64'h1000);
    check("ld_be",    r_be, 8'hFF);
    check("ld_we",    r_we, 1'b0);
    check("ld_valid", r_valid, 1'b1);
    check("ld_data",  r_data, 64'h1122334455667788);
    check("ld_code",  r_code, 4'hF);
    @(posedge clk); #2;
    check("ld_valid_pulse", bus.o_load_valid_m, 1'b0);
    check("ld_data_hold",   bus.o_load_data_m, 64'h1122334455667788);

    // LW / LWU from the upper word lane.
    run_access(64'h1004, 64'h0, 0, 1, 3'b010, 1, 1, 64'h89ABCDEF_00000000, 0, 0, 0);
    check("lw_be",   r_be, 8'hF0);
    check("lw_data", r_data, 64'hFFFFFFFF_89ABCDEF);
    run_access(64'h1004, 64'h0, 0, 1, 3'b110, 1, 1, 64'h89ABCDEF_00000000, 0, 0, 0);
    check("lwu_data", r_data, 64'h00000000_89ABCDEF);

    // SB into lane 1.
    run_access(64'h2001, 64'h5A, 1, 0, 3'b000, 1, 1, 64'h0, 0, 0, 0);
    check("sb_be",    r_be, 8'h02);
    check("sb_wdata", r_wdata, 64'h5A00);
    check("sb_we",    r_we, 1'b1);
    check("sb_valid", r_valid, 1'b0);

    // LB / LBU at byte 3.
    run_access(64'h1003, 64'h0, 0, 1, 3'b000, 1, 1, 64'h00000000_80000000, 0, 0, 0);
    check("lb_be",   r_be, 8'h08);
    check("lb_addr", r_addr, 64'h1000);
    check("lb_data", r_data, 64'hFFFFFFFFFFFFFF80);
    run_access(64'h1003, 64'h0, 0, 1, 3'b100, 1, 1, 64'h00000000_80000000, 0, 0, 0);
    check("lbu_data", r_data, 64'h80);

    // SH with grant on the fourth request cycle.
    run_access(64'h2006, 64'hABCD, 1, 0, 3'b001, 4, 1, 64'h0, 0, 0, 0);
    check("sh_req",    r_req, 4);
    check("sh_stable", r_stable, 1'b1);
    check("sh_addr",   r_addr, 64'h2000);
    check("sh_be",     r_be, 8'hC0);
    check("sh_wdata",  r_wdata, 64'hABCD000000000000);
    check("sh_stall",  r_stall, 6);
    check("sh_valid",  r_valid, 1'b0);
    check("sh_code",   r_code, 4'hF);

    // Misaligned accesses: immediate code, no bus, no stall.
    run_access(64'h1002, 64'h0, 0, 1, 3'b010, 1, 1, 64'h0, 0, 0, 0);
    check("lw_mis_code",  r_code, 4'd4);
    check("lw_mis_req",   r_req, 0);
    check("lw_mis_stall", r_stall, 0);
    run_access(64'h3004, 64'h1234, 1, 0, 3'b011, 1, 1, 64'h0, 0, 0, 0);
    check("sd_mis_code",  r_code, 4'd6);
    check("sd_mis_stall", r_stall, 0);

    // Bus errors.
    run_access(64'h1008, 64'h0, 0, 1, 3'b010, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
    check("ld_err_code",  r_code, 4'd5);
    check("ld_err_valid", r_valid, 1'b0);
    check("ld_err_data",  r_data, 64'h80);
    run_access(64'h100C, 64'h77, 1, 0, 3'b010, 1, 1, 64'h0, 1, 0, 0);
    check("st_err_code",  r_code, 4'd7);

    // Flush before grant: request withdrawn, back to idle.
    run_access(64'h1000, 64'h0, 0, 1, 3'b011, 10, 1, 64'h0, 0, 2, 0);
    check("flq_req",     r_req, 2);
    check("flq_stall",   r_stall, 3);
    check("flq_req_end", r_req_end, 1'b0);
    check("flq_valid",   r_valid, 1'b0);
    check("flq_code",    r_code, 4'hF);

    // Flush while waiting for the response: drains, completes silently.
    run_access(64'h1010, 64'h0, 0, 1, 3'b010, 1, 3, 64'h0000_0000_1234_5678, 0, 0, 1);
    check("flr_stall", r_stall, 5);
    check("flr_valid", r_valid, 1'b0);
    check("flr_code",  r_code, 4'hF);
    check("flr_data",  r_data, 64'h80);

    // Reset in the middle of a response wait, then a stale rvalid.
    @(posedge clk); #1;
    bus.i_alu_out_m = 64'h1018; bus.i_f3_m = 3'b011; bus.i_result_src_m = 2'b01;
    @(posedge clk); #1; bus.i_dbus_gnt = 1'b1;
    @(posedge clk); #1; bus.i_dbus_gnt = 1'b0; bus.i_result_src_m = 2'b00;
    #1;
    check("rsm_stall_pre", bus.o_stall_m, 1'b1);
    rst = 1'b1; #1;
    check("rsm_stall", bus.o_stall_m, 1'b0);
    check("rsm_addr",  bus.o_dbus_addr, 64'h0);
    check("rsm_data",  bus.o_load_data_m, 64'h0);
    check("rsm_code",  bus.o_exception_code_m, 4'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_dbus_rvalid = 1'b1; bus.i_dbus_rdata = 64'hCAFE_F00D_CAFE_F00D;
    @(posedge clk); #1;
    bus.i_dbus_rvalid = 1'b0;
    #1;
    check("late_rv_valid", bus.o_load_valid_m, 1'b0);
    check("late_rv_data",  bus.o_load_data_m, 64'h0);
    check("late_rv_stall", bus.o_stall_m, 1'b0);
    check("late_rv_req",   bus.o_dbus_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. It consumes the M-stage outputs of the EX/MEM pipeline register and executes the access on the data bus.
- Drives a request/grant/response data-bus handshake, holds the pipeline with a stall while an access is outstanding, and aligns and extends load data for writeback.
- Detects misaligned and faulting accesses and reports them as exception codes.

Parameters:
XLEN, `XLEN_64b, width select; data width W = 1<<(XLEN+4); 1 = 32-bit, 2 = 64-bit.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_flush  in  1  kill current M-stage access (trap/redirect)
i_alu_out_m  in  W  byte address
i_haz_b_m  in  W  store data (LSB-aligned)
i_mem_write_m  in  1  store request
i_result_src_m  in  2  2'b01 = load
i_f3_m  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
o_stall_m  out  1  freeze IF..EX/MEM while high
o_dbus_req  out  1  bus request
o_dbus_we  out  1  1 = write
o_dbus_addr  out  W  address aligned to W/8 bytes
o_dbus_wdata  out  W  store data shifted into byte lane
o_dbus_be  out  W/8  byte enables
i_dbus_gnt  in  1  request accepted
i_dbus_rvalid  in  1  response valid (load data or store ack)
i_dbus_rdata  in  W  read data
i_dbus_err  in  1  bus error, qualified by rvalid
o_load_data_m  out  W  aligned, extended load result
o_load_valid_m  out  1  one-cycle strobe, load data valid
o_exception_code_m  out  4  4'b1111 none; 4 load misaligned; 5 load fault; 6 store misaligned; 7 store fault

Behaviour:
- Access = i_mem_write_m | (i_result_src_m == 2'b01). Store takes priority if both are set.
- Size = 1 << f3[1:0] bytes. D (011) is illegal when W=32 and is treated as misaligned.
- Misaligned when addr mod size != 0.
- Lane offset = addr mod (W/8).
- o_dbus_be = ((1<<size)-1) << offset.
- o_dbus_wdata = i_haz_b_m << (8*offset).
- FSM states:
  - IDLE: if access and not misaligned and not i_flush, go to REQ.
  - REQ: on i_dbus_gnt, go to RESP.
  - RESP: on i_dbus_rvalid, go to DONE.
  - DONE: return to IDLE.
- Stall logic:
  - o_stall_m = (IDLE & access & ~misaligned & ~i_flush) | REQ | RESP.
  - o_stall_m is combinational; it is low in DONE so the pipeline advances.
- Bus signals:
  - o_dbus_req is high only in REQ. o_dbus_addr, o_dbus_we, o_dbus_be and o_dbus_wdata are registered at IDLE->REQ and held stable until grant.
  - Outside REQ, o_dbus_be = 0.
- Minimum access latency: 3 stall cycles (IDLE-detect, REQ with same-cycle gnt, RESP with next-cycle rvalid), then DONE.
- Response capture:
  - On rvalid, the lane is shifted down by offset, truncated to size, and sign- or zero-extended per f3[2]. The result is registered into o_load_data_m.
  - In DONE, o_load_valid_m = 1 for loads without error; it is 0 for stores.
  - o_load_data_m holds its value until the next load completes.
- Exceptions:
  - Misaligned: o_exception_code_m is driven combinationally in IDLE (4 or 6), no bus activity, no stall.
  - i_dbus_err with rvalid: code 5 or 7 in DONE, and o_load_valid_m = 0.
  - In all other cases, 4'b1111.
- i_flush handling:
  - In IDLE: no access is started.
  - In REQ before grant: go to IDLE immediately, req drops.
  - In REQ with same-cycle gnt, or in RESP: the access is marked killed. The FSM still waits for rvalid (bus must drain). On response it goes through DONE with load_valid = 0 and code 4'b1111. Stall stays high until DONE.
- Reset, asynchronous and any time including mid-access:
  - State goes to IDLE.
  - o_dbus_req, o_dbus_we, o_load_valid_m, o_dbus_be, o_dbus_addr, o_dbus_wdata and o_load_data_m go to 0.
  - o_exception_code_m = 4'b1111.
  - Outstanding responses after reset are ignored while in IDLE.
- i_dbus_gnt or i_dbus_rvalid arriving in an unexpected state (IDLE, DONE) is ignored.

Test Plan:
1. W=64: LD at 0x1000, gnt same cycle, rvalid next cycle with rdata 0x1122334455667788 -> stall high 3 cycles; DONE: load_valid=1, load_data=0x1122334455667788, code 1111.
2. LB at 0x1003, rdata 0x00000000_80000000 -> be=0x08, load_data=0xFFFFFFFFFFFFFF80. Same access as LBU -> load_data=0x80.
3. SH at 0x2006, haz_b=0xABCD, gnt delayed 4 cycles -> req held 4 cycles with address, be and wdata stable; addr=0x2000, be=0xC0, wdata=0xABCD000000000000; stall until DONE; load_valid=0.
4. LW at 0x1002 -> code 4 the same cycle, no req, no stall. SD at 0x3004 -> code 6.
5. Load with rvalid and err=1 -> code 5 in DONE, load_valid=0. Store with rvalid and err=1 -> code 7.
6. Flush: flush in REQ before gnt -> req drops next cycle, returns to IDLE. Flush in RESP -> waits for rvalid, DONE with load_valid=0 and code 1111. Reset asserted in RESP -> outputs at reset values immediately; a late rvalid is ignored.
